// File: rtl/restoring_divider_8_by_4_if.sv
// ============================================================================
// restoring_divider_8_by_4_if : request/result bundle for the 8-by-4 divider
// Revision 1.0
// ============================================================================
`default_nettype none

interface restoring_divider_8_by_4_if;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero
   );
endinterface

`default_nettype wire

// File: rtl/restoring_divider_8_by_4.sv
// ============================================================================
// restoring_divider_8_by_4 : sequential 8-bit / 4-bit restoring divider with
// 7-segment display of quotient and remainder.
// Revision 1.0
// ============================================================================
`default_nettype none

module restoring_divider_8_by_4 (
   input  wire logic                  CLOCK_50,
   input  wire logic [0:0]            KEY,
   restoring_divider_8_by_4_if.slave  bus,
   output logic [0:6]                 HEX3,
   output logic [0:6]                 HEX2,
   output logic [0:6]                 HEX0
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] dvd;
   logic [3:0] dvs;
   logic [4:0] prem;
   logic [7:0] qacc;
   logic [2:0] cnt;

   logic [4:0] shifted;
   logic [5:0] diff;
   logic       qbit;
   logic [4:0] next_prem;

   // Partial remainder never exceeds 2*14+1, so 5 bits plus a borrow bit suffice.
   always_comb begin
      shifted   = {prem[3:0], dvd[7]};
      diff      = {1'b0, shifted} - {2'b00, dvs};
      qbit      = ~diff[5];
      next_prem = qbit ? diff[4:0] : shifted;
   end

   always_ff @(posedge CLOCK_50 or negedge KEY[0]) begin
      if (!KEY[0]) begin
         state           <= IDLE;
         dvd             <= 8'd0;
         dvs             <= 4'd0;
         prem            <= 5'd0;
         qacc            <= 8'd0;
         cnt             <= 3'd0;
         bus.quotient    <= 8'd0;
         bus.remainder   <= 4'd0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  dvd  <= bus.dividend;
                  dvs  <= bus.divisor;
                  prem <= 5'd0;
                  qacc <= 8'd0;
                  cnt  <= 3'd0;
                  if (bus.divisor == 4'd0) begin
                     bus.quotient    <= 8'hFF;
                     bus.remainder   <= 4'hF;
                     bus.div_by_zero <= 1'b1;
                     bus.done        <= 1'b1;
                     state           <= DONE;
                  end else begin
                     bus.busy <= 1'b1;
                     state    <= RUN;
                  end
               end
            end
            RUN: begin
               dvd  <= {dvd[6:0], 1'b0};
               prem <= next_prem;
               qacc <= {qacc[6:0], qbit};
               cnt  <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  bus.quotient    <= {qacc[6:0], qbit};
                  bus.remainder   <= next_prem[3:0];
                  bus.div_by_zero <= 1'b0;
                  bus.busy        <= 1'b0;
                  bus.done        <= 1'b1;
                  state           <= DONE;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   function automatic logic [0:6] seg7(input logic [3:0] v);
      logic [0:6] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Results are zero during reset, so the digits naturally read 0 then.
   always_comb begin
      if (bus.busy) begin
         HEX3 = 7'b1111111;
         HEX2 = 7'b1111111;
         HEX0 = 7'b1111111;
      end else begin
         HEX3 = seg7(bus.quotient[7:4]);
         HEX2 = seg7(bus.quotient[3:0]);
         HEX0 = seg7(bus.remainder);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider_8_by_4.sv
// ============================================================================
// tb_restoring_divider_8_by_4 : directed and exhaustive checks of the divider
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_restoring_divider_8_by_4;

   logic       clk;
   logic [0:0] key;
   logic [0:6] hex3, hex2, hex0;
   int         vectors;
   int         miscompares;

   restoring_divider_8_by_4_if bus ();

   restoring_divider_8_by_4 dut (
      .CLOCK_50 (clk),
      .KEY      (key),
      .bus      (bus.slave),
      .HEX3     (hex3),
      .HEX2     (hex2),
      .HEX0     (hex0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launch one operation, follow it to the done pulse and check everything.
   task automatic do_div(input logic [7:0] dd, input logic [3:0] dv,
                         input logic [7:0] eq, input logic [3:0] er,
                         input logic edz, input int elat, input bit disturb);
      int cycles;
      int busy_cycles;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = dd;
      bus.divisor  = dv;
      @(posedge clk);
      #1;
      bus.start   = 1'b0;
      cycles      = 1;
      busy_cycles = 0;
      while (!bus.done && cycles < 20) begin
         if (bus.busy) busy_cycles++;
         if (cycles == 1 && bus.busy)
            chk("hex_blank", {hex3, hex2, hex0}, {21{1'b1}});
         if (disturb && cycles == 2) begin
            bus.start    = 1'b1;
            bus.dividend = 8'd50;
            bus.divisor  = 4'd5;
         end
         if (disturb && cycles == 4) begin
            bus.start    = 1'b0;
            bus.dividend = 8'hAA;
            bus.divisor  = 4'd0;
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      bus.start = 1'b0;
      chk("latency", cycles, elat);
      chk("busy_cycles", busy_cycles, (elat == 9) ? 8 : 0);
      chk("quotient", bus.quotient, eq);
      chk("remainder", bus.remainder, er);
      chk("div_by_zero", bus.div_by_zero, edz);
      @(posedge clk);
      #1;
      chk("done_one_cycle", bus.done, 1'b0);
      chk("quotient_held", bus.quotient, eq);
   endtask

   initial begin
      bit saw_done;
      vectors      = 0;
      miscompares  = 0;
      key          = 1'b0;
      bus.start    = 1'b0;
      bus.dividend = 8'd0;
      bus.divisor  = 4'd0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_quotient", bus.quotient, 8'd0);
      chk("rst_remainder", bus.remainder, 4'd0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_dbz", bus.div_by_zero, 1'b0);
      chk("rst_hex", {hex3, hex2, hex0}, {7'b1000000, 7'b1000000, 7'b1000000});
      key = 1'b1;

      // 200/7 accepted on the first edge after release
      do_div(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 9, 1'b0);
      chk("hex3_200_7", hex3, 7'b1111001);
      chk("hex2_200_7", hex2, 7'b1000110);
      chk("hex0_200_7", hex0, 7'b0011001);

      do_div(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 9, 1'b0);
      do_div(8'd3, 4'd9, 8'd0, 4'd3, 1'b0, 9, 1'b0);

      do_div(8'd5, 4'd0, 8'hFF, 4'hF, 1'b1, 1, 1'b0);
      chk("hex3_div0", hex3, 7'b0001110);
      chk("hex0_div0", hex0, 7'b0001110);

      // Start and operand changes during RUN must be ignored
      do_div(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 9, 1'b1);
      @(posedge clk);
      #1;
      chk("no_queued_start", bus.busy, 1'b0);

      // Asynchronous reset during the 4th RUN cycle
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 8'd200;
      bus.divisor  = 4'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("pre_rst_busy", bus.busy, 1'b1);
      key = 1'b0;
      #1;
      chk("midrst_quotient", bus.quotient, 8'd0);
      chk("midrst_remainder", bus.remainder, 4'd0);
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_done", bus.done, 1'b0);
      chk("midrst_dbz", bus.div_by_zero, 1'b0);
      chk("midrst_hex", {hex3, hex2, hex0}, {7'b1000000, 7'b1000000, 7'b1000000});
      saw_done = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      chk("midrst_no_done", saw_done, 1'b0);
      key = 1'b1;
      do_div(8'd15, 4'd4, 8'd3, 4'd3, 1'b0, 9, 1'b0);

      // Exhaustive sweep against a reference model
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0)
               do_div(8'(a), 4'(b), 8'hFF, 4'hF, 1'b1, 1, 1'b0);
            else
               do_div(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 9, 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/restoring_divider_8_by_4.md
RESTORING_DIVIDER_8_BY_4 -- requirements
Module: restoring_divider_8_by_4

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 KEY  input  1  KEY[0]: asynchronous, active-low reset (0 = reset).
REQ-005 start  input  1  synchronous request pulse; sampled only in IDLE.
REQ-006 dividend  input  8  unsigned dividend; captured when start is accepted.
REQ-007 divisor  input  4  unsigned divisor; captured when start is accepted.
REQ-008 quotient  output  8  registered unsigned quotient.
REQ-009 remainder  output  4  registered unsigned remainder.
REQ-010 busy  output  1  high while the division iterates.
REQ-011 done  output  1  one-cycle pulse when results update.
REQ-012 div_by_zero  output  1  registered flag for the last accepted operation.
REQ-013 HEX3, HEX2, HEX0  output  7 each, indexed [0:6]  active-low 7-segment digits: quotient[7:4], quotient[3:0], remainder.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE with start=1 at edge E0: capture operands, clear the partial remainder, set the iteration counter to 0, go to RUN.
REQ-016 IDLE with start=1 and captured divisor=0 at E0: go directly to DONE and load quotient=8'hFF, remainder=4'hF, div_by_zero=1.
REQ-017 Each RUN cycle SHALL process one dividend bit, MSB first: shift the 5-bit partial remainder left and insert the next dividend bit; trial-subtract the divisor; if the result is not negative, keep it and set the quotient bit to 1, else restore and set the bit to 0.
REQ-018 RUN SHALL last exactly 8 cycles (edges E1..E8). At E8, quotient, remainder and div_by_zero=0 load together and the state goes to DONE.
REQ-019 DONE SHALL last one cycle, then return unconditionally to IDLE; done=1 only while in DONE.
REQ-020 busy SHALL be 1 exactly while in RUN.
REQ-021 Latency from start acceptance to done: 9 cycles for a nonzero divisor, 1 cycle for a zero divisor.
REQ-022 start in RUN or DONE SHALL be ignored and not queued; operand changes after E0 SHALL NOT affect the result.
REQ-023 quotient, remainder and div_by_zero SHALL change only at the RUN-to-DONE or IDLE-to-DONE transition; at all other times they hold.
REQ-024 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor from 1 to 15.
REQ-025 The HEX outputs SHALL use active-low hex encoding (0=1000000, 1=1111001, ... A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110).
REQ-026 All HEX outputs SHALL be blank (1111111) while busy=1.

Reset
REQ-027 KEY[0]=0 SHALL immediately force the state to IDLE, with quotient=0, remainder=0, busy=0, done=0 and div_by_zero=0, regardless of the clock and even in mid-RUN.
REQ-028 While in reset, the HEX outputs SHALL show 0 (1000000).
REQ-029 After KEY[0] returns to 1, the block SHALL accept start on the first rising edge.
REQ-030 A reset during RUN SHALL discard the operation; no done pulse follows.

Verification
REQ-031 200/7 -> busy high for 8 cycles, done 9 cycles after acceptance, quotient=28 (0x1C), remainder=4; HEX3=1111001, HEX2=1000110, HEX0=0011001.
REQ-032 255/1 -> quotient=255, remainder=0, div_by_zero=0; 3/9 -> quotient=0, remainder=3.
REQ-033 5/0 -> done on the cycle after acceptance, quotient=0xFF, remainder=0xF, div_by_zero=1, busy never asserted.
REQ-034 Start 100/3, then pulse start with 50/5 and change the operands during RUN -> result stays quotient=33, remainder=1; exactly one done pulse.
REQ-035 Start 200/7, then set KEY[0]=0 at the 4th RUN cycle -> all outputs zero immediately, no done; after release, 15/4 -> quotient=3, remainder=3.
REQ-036 Exhaustive sweep of all 256x16 operand pairs with a golden model -> every result and latency matches REQ-016 to REQ-024.
